// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  typedef logic [4:0] digit_t;

  localparam digit_t DIG_EVEN_RST = 5'b00000;
  localparam digit_t DIG_ODD_RST  = 5'b10000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, counter-digit and display signals between board/counter and the sequencer.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic   btn_start;
  logic   btn_lap;
  logic   btn_clear;
  digit_t digit0_in;
  digit_t digit1_in;
  digit_t digit2_in;
  digit_t digit3_in;
  logic   cnt_enable;
  logic   cnt_reset;
  digit_t disp0;
  digit_t disp1;
  digit_t disp2;
  digit_t disp3;
  logic   running;
  logic   lap_active;

  modport master (
    output btn_start, btn_lap, btn_clear,
    output digit0_in, digit1_in, digit2_in, digit3_in,
    input  cnt_enable, cnt_reset, disp0, disp1, disp2, disp3, running, lap_active
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear,
    input  digit0_in, digit1_in, digit2_in, digit3_in,
    output cnt_enable, cnt_reset, disp0, disp1, disp2, disp3, running, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_pulse.sv
// One push-button front end: 2-flop synchronizer, debounce, one-cycle pulse on accepted press.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DB_W            = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            vld1_q, vld2_q, armed_q;
  logic            level_q, level_d, level_dly_q;
  logic            pulse_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // armed_q only sets once a real released sample has crossed the synchronizer,
  // so a button held through reset cannot produce a press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      vld1_q      <= 1'b1;
      vld2_q      <= vld1_q;
      armed_q     <= armed_q | (vld2_q & ~sync2_q);
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= level_q & ~level_dly_q & armed_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap sequencer: drives the counter enable/reset and selects live or frozen digits.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DB_W            = 20
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);
  logic                p_start, p_lap, p_clear;
  state_e              state_q, state_d;
  logic                cnt_enable_q, cnt_reset_q;
  logic                snap_load, clr_pulse;
  logic [3:0][4:0]     snap_q, live, shown;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_start (
    .clk(clk), .reset(reset), .btn_i(sw.btn_start), .pulse_o(p_start));
  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_lap (
    .clk(clk), .reset(reset), .btn_i(sw.btn_lap), .pulse_o(p_lap));
  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_clear (
    .clk(clk), .reset(reset), .btn_i(sw.btn_clear), .pulse_o(p_clear));

  assign live = {sw.digit3_in, sw.digit2_in, sw.digit1_in, sw.digit0_in};

  // Per-state if/else chains give clear > start > lap among the pulses valid there.
  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    clr_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p_clear)      clr_pulse = 1'b1;
        else if (p_start) state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (p_start) state_d = ST_PAUSE;
        else if (p_lap) begin
          state_d   = ST_LAP;
          snap_load = 1'b1;
        end
      end
      ST_LAP: begin
        if (p_clear)      state_d   = ST_RUN;
        else if (p_start) state_d   = ST_PAUSE;
        else if (p_lap)   snap_load = 1'b1;
      end
      ST_PAUSE: begin
        if (p_clear) begin
          state_d   = ST_IDLE;
          clr_pulse = 1'b1;
        end else if (p_start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_enable_q <= 1'b0;
      cnt_reset_q  <= 1'b0;
      snap_q       <= {DIG_ODD_RST, DIG_EVEN_RST, DIG_ODD_RST, DIG_EVEN_RST};
    end else begin
      state_q      <= state_d;
      cnt_enable_q <= (state_d == ST_RUN) || (state_d == ST_LAP);
      cnt_reset_q  <= clr_pulse;
      if (snap_load) snap_q <= live;
    end
  end

  assign shown         = (state_q == ST_LAP) ? snap_q : live;
  assign sw.disp0      = shown[0];
  assign sw.disp1      = shown[1];
  assign sw.disp2      = shown[2];
  assign sw.disp3      = shown[3];
  assign sw.cnt_enable = cnt_enable_q;
  assign sw.cnt_reset  = cnt_reset_q;
  assign sw.running    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign sw.lap_active = (state_q == ST_LAP);
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n_start = 0, n_lap = 0, n_clear = 0, n_creset = 0;
  int   nl;

  localparam logic [19:0] D1      = 20'b10011_00101_10111_00010;
  localparam logic [19:0] D2      = 20'b00001_10010_00011_10100;
  localparam logic [19:0] D3      = 20'b11111_01010_00100_11001;
  localparam logic [19:0] SNAP_RST = 20'b10000_00000_10000_00000;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk(clk), .reset(reset), .sw(sw));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (dut.p_start)      n_start++;
    if (dut.p_lap)        n_lap++;
    if (dut.p_clear)      n_clear++;
    if (sw.cnt_reset)     n_creset++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dig(input logic [19:0] v);
    {sw.digit3_in, sw.digit2_in, sw.digit1_in, sw.digit0_in} = v;
  endtask

  function automatic logic [19:0] disp_all();
    return {sw.disp3, sw.disp2, sw.disp1, sw.disp0};
  endfunction

  // m = {clear, lap, start}; held long enough to act, then released and settled
  task automatic press(input logic [2:0] m);
    {sw.btn_clear, sw.btn_lap, sw.btn_start} = m;
    tick(8);
    {sw.btn_clear, sw.btn_lap, sw.btn_start} = 3'b000;
    tick(10);
  endtask

  initial begin
    reset = 1'b1;
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_clear = 1'b0;
    set_dig(20'h12345);
    tick(3);
    reset = 1'b0;
    chk("rst_outputs", {28'd0, sw.cnt_enable, sw.cnt_reset, sw.running, sw.lap_active}, 32'd0);
    chk("rst_snapshot", {12'd0, dut.snap_q}, {12'd0, SNAP_RST});
    chk("rst_disp_live", {12'd0, disp_all()}, {12'd0, 20'h12345});
    tick(4);

    // clean start press: enable rises on the 8th edge after the raw edge
    sw.btn_start = 1'b1;
    tick(7);
    chk("start_lat_before", {31'd0, sw.cnt_enable}, 32'd0);
    tick(1);
    chk("start_lat_enable", {31'd0, sw.cnt_enable}, 32'd1);
    chk("start_running", {31'd0, sw.running}, 32'd1);
    tick(2);
    sw.btn_start = 1'b0;
    tick(10);
    chk("start_one_pulse", n_start, 1);

    // bounce shorter than the window is rejected, then a stable press pauses
    for (int i = 0; i < 10; i++) begin
      sw.btn_start = ~sw.btn_start;
      tick(2);
    end
    chk("bounce_no_pulse", n_start, 1);
    chk("bounce_still_run", {31'd0, sw.cnt_enable}, 32'd1);
    sw.btn_start = 1'b1;
    tick(7);
    chk("bounce_hold_before", {31'd0, sw.cnt_enable}, 32'd1);
    tick(1);
    chk("bounce_hold_pause", {31'd0, sw.cnt_enable}, 32'd0);
    chk("bounce_one_pulse", n_start, 2);
    sw.btn_start = 1'b0;
    tick(10);

    // lap freeze, split, and release
    press(3'b001);
    set_dig(D1);
    press(3'b010);
    chk("lap_flags", {29'd0, sw.lap_active, sw.running, sw.cnt_enable}, 32'd7);
    chk("lap_disp", {12'd0, disp_all()}, {12'd0, D1});
    set_dig(D2);
    tick(1);
    chk("lap_frozen", {12'd0, disp_all()}, {12'd0, D1});
    press(3'b010);
    chk("split_disp", {12'd0, disp_all()}, {12'd0, D2});
    set_dig(D3);
    tick(1);
    chk("split_frozen", {12'd0, disp_all()}, {12'd0, D2});
    press(3'b100);
    chk("lapclr_flags", {30'd0, sw.lap_active, sw.cnt_enable}, 32'd1);
    chk("lapclr_live", {12'd0, disp_all()}, {12'd0, D3});

    // clear ignored in RUN
    press(3'b100);
    chk("runclr_enable", {31'd0, sw.cnt_enable}, 32'd1);
    chk("runclr_no_creset", n_creset, 0);

    // clear in PAUSE: one-cycle counter reset, back to IDLE
    press(3'b001);
    chk("pause_flags", {30'd0, sw.running, sw.cnt_enable}, 32'd0);
    sw.btn_clear = 1'b1;
    tick(8);
    chk("pclr_creset_hi", {30'd0, sw.cnt_reset, sw.cnt_enable}, 32'd2);
    tick(1);
    chk("pclr_creset_lo", {31'd0, sw.cnt_reset}, 32'd0);
    sw.btn_clear = 1'b0;
    tick(10);
    chk("pclr_one_cycle", n_creset, 1);

    // simultaneous start+clear in PAUSE: clear wins
    press(3'b001);
    press(3'b001);
    chk("pause2_running", {31'd0, sw.running}, 32'd0);
    sw.btn_start = 1'b1;
    sw.btn_clear = 1'b1;
    tick(8);
    chk("both_creset_hi", {29'd0, sw.cnt_reset, sw.running, sw.cnt_enable}, 32'd4);
    tick(1);
    chk("both_creset_lo", {31'd0, sw.cnt_reset}, 32'd0);
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    tick(10);
    chk("both_idle", {30'd0, sw.running, sw.cnt_enable}, 32'd0);
    chk("both_creset_cnt", n_creset, 2);

    // reset in LAP with lap held: no pulse until released and pressed again
    press(3'b001);
    sw.btn_lap = 1'b1;
    tick(8);
    chk("pre_rst_lap", {31'd0, sw.lap_active}, 32'd1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("midrst_outputs", {28'd0, sw.cnt_enable, sw.cnt_reset, sw.running, sw.lap_active}, 32'd0);
    chk("midrst_snapshot", {12'd0, dut.snap_q}, {12'd0, SNAP_RST});
    nl = n_lap;
    tick(3);
    sw.btn_start = 1'b1;
    tick(8);
    chk("held_run", {31'd0, sw.running}, 32'd1);
    sw.btn_start = 1'b0;
    tick(10);
    chk("held_no_lap", {31'd0, sw.lap_active}, 32'd0);
    chk("held_no_pulse", n_lap, nl);
    sw.btn_lap = 1'b0;
    tick(10);
    press(3'b010);
    chk("repress_lap", {31'd0, sw.lap_active}, 32'd1);
    chk("repress_pulse", n_lap, nl + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
